hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Drives stall/flush of the
//  fetch->decode and decode->exec pipeline registers, and the exec-stage forwarding
//  selects. Sequences multi-cycle exec operations (MUL/DIV) through a wait FSM
//  with a timeout. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MC_TIMEOUT  64  max cycles in MC_WAIT before forced abort (>=2)
//  CNT_W       32  width of stall_cycles counter
// PORTS
//  clk             in   1   system clock, all state on posedge
//  reset           in   1   asynchronous, active-low reset
//  rs1_decode      in   5   source reg 1 of instr in decode
//  rs2_decode      in   5   source reg 2 of instr in decode
//  rs1_exec        in   5   source reg 1 of instr in exec
//  rs2_exec        in   5   source reg 2 of instr in exec
//  rd_exec         in   5   dest reg of instr in exec
//  is_load_exec    in   1   instr in exec is a load
//  rd_mem          in   5   dest reg in mem stage
//  reg_write_mem   in   1   mem-stage instr writes rd_mem
//  rd_wb           in   5   dest reg in writeback
//  reg_write_wb    in   1   wb-stage instr writes rd_wb
//  pc_src_exec     in   1   taken branch/jump resolved in exec
//  mc_start_exec   in   1   multi-cycle op enters exec (1-cycle pulse)
//  mc_done         in   1   multi-cycle unit result valid
//  stall_fetch     out  1   hold PC and fetch->decode register
//  stall_decode    out  1   hold decode->exec register
//  stall_exec      out  1   hold exec->mem register
//  flush_decode    out  1   clear fetch->decode register
//  flush_exec      out  1   clear decode->exec register
//  fwd_a_exec      out  2   ALU src A: 00 regfile, 01 wb result, 10 mem result
//  fwd_b_exec      out  2   ALU src B: same encoding
//  mc_error        out  1   sticky: multi-cycle timeout occurred
//  stall_cycles    out  CNT_W  count of cycles with stall_fetch=1, saturating
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN, timer=0, mc_error=0, stall_cycles=0; all
//   stall/flush outputs 0 and fwd_* 00 while reset is low regardless of inputs.
//  Forwarding (comb, every state): fwd_a=10 if reg_write_mem & rd_mem!=0 &
//   rd_mem==rs1_exec; else 01 if reg_write_wb & rd_wb!=0 & rd_wb==rs1_exec; else 00.
//   fwd_b identical on rs2_exec. Mem match beats wb match.
//  Load-use (comb, RUN only): lu = is_load_exec & rd_exec!=0 &
//   (rd_exec==rs1_decode | rd_exec==rs2_decode) -> stall_fetch=1, stall_decode=1,
//   flush_exec=1 for that cycle (one bubble). x0 never hazards.
//  Branch (comb, RUN only): pc_src_exec -> flush_decode=1, flush_exec=1, stalls=0.
//   Branch wins over load-use in the same cycle (lu ignored; wrong-path instr).
//  FSM states RUN, MC_WAIT:
//   RUN -> MC_WAIT on mc_start_exec & !mc_done & !pc_src_exec; timer<=0.
//   mc_start_exec with mc_done same cycle: 0-wait, stay RUN.
//   MC_WAIT: stall_fetch=stall_decode=stall_exec=1, no flushes; timer++ each cycle.
//   MC_WAIT -> RUN on mc_done (stalls drop same cycle mc_done is seen).
//   MC_WAIT -> RUN when timer==MC_TIMEOUT-1 & !mc_done; set mc_error=1, assert
//    flush_exec=1 that cycle to drop the op. mc_done on that cycle wins (no error).
//   pc_src_exec/lu ignored while in MC_WAIT.
//  mc_error cleared only by reset.
//  stall_cycles increments on every posedge with stall_fetch=1; holds at all-ones.
//  Reset mid-MC_WAIT: immediate return to RUN, outputs low, no error recorded.
// STRUCTURE
//  Shared package/header (core_defs.vh): FWD_REG=2'b00, FWD_WB=2'b01,
//   FWD_MEM=2'b10; ST_RUN/ST_MC_WAIT encodings; REG_ADDR_W=5.
//  One natural sub-module: fwd_sel (combinational, one instance per ALU operand).
//  FSM, timer and perf counter live in hazard_ctrl.
// TESTING
//  1 Reset: drive all inputs 1, reset=0 -> all outputs 0, stall_cycles=0.
//  2 Forward: rd_mem=5,reg_write_mem=1,rd_wb=5,reg_write_wb=1,rs1_exec=5 ->
//    fwd_a=10; rd_mem=0 same rest -> fwd_a=01; rs1_exec=0,rd_*=0 -> 00.
//  3 Load-use: is_load_exec=1,rd_exec=7,rs2_decode=7 -> stall_fetch/decode=1,
//    flush_exec=1 one cycle; add pc_src_exec=1 -> only flush_decode/flush_exec=1.
//  4 Multi-cycle: mc_start pulse, mc_done after 5 cycles -> stalls=1 for 5
//    cycles, drop on mc_done cycle, stall_cycles=5, mc_error=0.
//  5 Timeout: MC_TIMEOUT=8, mc_start, no mc_done -> 8 stall cycles, flush_exec=1
//    on 8th, mc_error=1 sticky, back to RUN; pc_src_exec mid-wait ignored.
//  6 Saturation: CNT_W=4, hold load-use 20 cycles -> stall_cycles=15 and holds;
//    reset mid-MC_WAIT -> state RUN, mc_error=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline sequencing controller: register
//   address width, forwarding-select encodings, controller FSM states and a
//   helper that decides whether a producer register feeds a consumer register.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [1:0]            fwd_t;

    localparam fwd_t FWD_REG = 2'b00;
    localparam fwd_t FWD_WB  = 2'b01;
    localparam fwd_t FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    // x0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic reg_hit(input reg_addr_t rd, input reg_addr_t rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_fwd_sel
//   Combinational forwarding select for one exec-stage ALU operand.
//   Ports:
//     rs_exec       in  source register of the operand in exec
//     rd_mem        in  destination register in mem stage
//     reg_write_mem in  mem-stage instruction writes rd_mem
//     rd_wb         in  destination register in writeback
//     reg_write_wb  in  wb-stage instruction writes rd_wb
//     sel           out FWD_MEM / FWD_WB / FWD_REG
// -----------------------------------------------------------------------------
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_exec,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  reg_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_write_wb,
    output logic [1:0]            sel
);

    // The mem-stage result is younger than the wb-stage one, so it wins.
    always_comb begin
        sel = FWD_REG;
        if (reg_write_mem && reg_hit(rd_mem, rs_exec)) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && reg_hit(rd_wb, rs_exec)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage core. Generates stall and
//   flush controls for the fetch->decode and decode->exec registers, the
//   exec-stage forwarding selects, sequences multi-cycle exec operations
//   through a wait state with timeout, and counts stalled cycles.
//   Ports:
//     clk, reset                 clock; asynchronous active-low reset
//     rs1/rs2_decode             sources of the instruction in decode
//     rs1/rs2_exec, rd_exec      sources / destination of the instruction in exec
//     is_load_exec               exec instruction is a load
//     rd_mem, reg_write_mem      mem-stage writer
//     rd_wb, reg_write_wb        wb-stage writer
//     pc_src_exec                taken branch/jump resolved in exec
//     mc_start_exec, mc_done     multi-cycle op start pulse / result valid
//     stall_fetch/decode/exec    hold controls
//     flush_decode/exec          clear controls
//     fwd_a_exec, fwd_b_exec     ALU operand forwarding selects
//     mc_error                   sticky multi-cycle timeout flag
//     stall_cycles               saturating count of stall_fetch cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_decode,
    input  logic [REG_ADDR_W-1:0] rs2_decode,
    input  logic [REG_ADDR_W-1:0] rs1_exec,
    input  logic [REG_ADDR_W-1:0] rs2_exec,
    input  logic [REG_ADDR_W-1:0] rd_exec,
    input  logic                  is_load_exec,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  reg_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_write_wb,
    input  logic                  pc_src_exec,
    input  logic                  mc_start_exec,
    input  logic                  mc_done,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  stall_exec,
    output logic                  flush_decode,
    output logic                  flush_exec,
    output logic [1:0]            fwd_a_exec,
    output logic [1:0]            fwd_b_exec,
    output logic                  mc_error,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned TIMER_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MC_TIMEOUT - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               load_use;
    logic               mc_timeout;
    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;

    hazard_ctrl_fwd_sel u_fwd_a (
        .rs_exec       (rs1_exec),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .sel           (fwd_a_raw)
    );

    hazard_ctrl_fwd_sel u_fwd_b (
        .rs_exec       (rs2_exec),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .sel           (fwd_b_raw)
    );

    // Forwarding is independent of the FSM; only reset masks it.
    assign fwd_a_exec = reset ? fwd_a_raw : FWD_REG;
    assign fwd_b_exec = reset ? fwd_b_raw : FWD_REG;

    always_comb begin
        load_use   = is_load_exec &&
                     (reg_hit(rd_exec, rs1_decode) || reg_hit(rd_exec, rs2_decode));
        mc_timeout = (state == ST_MC_WAIT) && (timer == TIMER_LAST) && !mc_done;
    end

    // Controls are combinational so a hazard or mc_done acts in the cycle it
    // is seen; reset low forces them all inactive.
    always_comb begin
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        stall_exec   = 1'b0;
        flush_decode = 1'b0;
        flush_exec   = 1'b0;
        if (reset) begin
            unique case (state)
                ST_RUN: begin
                    // A taken branch makes the decode instruction wrong-path,
                    // so its load-use hazard is irrelevant.
                    if (pc_src_exec) begin
                        flush_decode = 1'b1;
                        flush_exec   = 1'b1;
                    end else if (load_use) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        flush_exec   = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    if (!mc_done) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        stall_exec   = 1'b1;
                        flush_exec   = mc_timeout;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_RUN;
            timer        <= '0;
            mc_error     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stall_fetch && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            unique case (state)
                ST_RUN: begin
                    if (mc_start_exec && !mc_done && !pc_src_exec) begin
                        state <= ST_MC_WAIT;
                        timer <= '0;
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done) begin
                        state <= ST_RUN;
                    end else if (mc_timeout) begin
                        state    <= ST_RUN;
                        mc_error <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned MC_TIMEOUT = 8;
    localparam int unsigned CNT_W      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b0;
    logic [4:0]       rs1_decode, rs2_decode, rs1_exec, rs2_exec, rd_exec;
    logic             is_load_exec;
    logic [4:0]       rd_mem, rd_wb;
    logic             reg_write_mem, reg_write_wb;
    logic             pc_src_exec, mc_start_exec, mc_done;
    logic             stall_fetch, stall_decode, stall_exec;
    logic             flush_decode, flush_exec;
    logic [1:0]       fwd_a_exec, fwd_b_exec;
    logic             mc_error;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .rs1_decode    (rs1_decode),
        .rs2_decode    (rs2_decode),
        .rs1_exec      (rs1_exec),
        .rs2_exec      (rs2_exec),
        .rd_exec       (rd_exec),
        .is_load_exec  (is_load_exec),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .pc_src_exec   (pc_src_exec),
        .mc_start_exec (mc_start_exec),
        .mc_done       (mc_done),
        .stall_fetch   (stall_fetch),
        .stall_decode  (stall_decode),
        .stall_exec    (stall_exec),
        .flush_decode  (flush_decode),
        .flush_exec    (flush_exec),
        .fwd_a_exec    (fwd_a_exec),
        .fwd_b_exec    (fwd_b_exec),
        .mc_error      (mc_error),
        .stall_cycles  (stall_cycles)
    );

    typedef struct packed {
        logic       sf, sd, se, fd, fe;
        logic [1:0] fa, fb;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic sf, input logic sd, input logic se,
                                input logic fd, input logic fe,
                                input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_t e;
        e.sf = sf; e.sd = sd; e.se = se; e.fd = fd; e.fe = fe;
        e.fa = fa; e.fb = fb; e.err = err;
        return e;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                             input logic wm, input logic [4:0] rdw, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rs1_decode = '0; rs2_decode = '0; rs1_exec = '0; rs2_exec = '0; rd_exec = '0;
        is_load_exec = 1'b0; rd_mem = '0; rd_wb = '0;
        reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        pc_src_exec = 1'b0; mc_start_exec = 1'b0; mc_done = 1'b0;
    endtask

    task automatic sample_cmp(input string tag);
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({tag, ".stall_fetch"},  32'(stall_fetch),  32'(e.sf));
            check_eq({tag, ".stall_decode"}, 32'(stall_decode), 32'(e.sd));
            check_eq({tag, ".stall_exec"},   32'(stall_exec),   32'(e.se));
            check_eq({tag, ".flush_decode"}, 32'(flush_decode), 32'(e.fd));
            check_eq({tag, ".flush_exec"},   32'(flush_exec),   32'(e.fe));
            check_eq({tag, ".fwd_a"},        32'(fwd_a_exec),   32'(e.fa));
            check_eq({tag, ".fwd_b"},        32'(fwd_b_exec),   32'(e.fb));
            check_eq({tag, ".mc_error"},     32'(mc_error),     32'(e.err));
        end
    endtask

    // Caller drives inputs just after a negedge; outputs are sampled 2ns later,
    // well before the next posedge.
    task automatic run(input string tag, input exp_t e);
        exp_q.push_back(e);
        #2;
        sample_cmp(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();

        // 1: reset with every input high
        @(negedge clk);
        reset = 1'b0;
        rs1_decode = '1; rs2_decode = '1; rs1_exec = '1; rs2_exec = '1; rd_exec = '1;
        is_load_exec = 1'b1; rd_mem = '1; rd_wb = '1; reg_write_mem = 1'b1;
        reg_write_wb = 1'b1; pc_src_exec = 1'b1; mc_start_exec = 1'b1; mc_done = 1'b1;
        run("rst0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        run("rst1", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("rst.cnt", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle();

        // 2: forwarding priority, then random patterns against the model
        @(negedge clk);
        rd_mem = 5'd5; reg_write_mem = 1'b1; rd_wb = 5'd5; reg_write_wb = 1'b1; rs1_exec = 5'd5;
        run("fwd.mem", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        @(negedge clk);
        rd_mem = 5'd0;
        run("fwd.wb", mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        @(negedge clk);
        rs1_exec = 5'd0; rd_wb = 5'd0;
        run("fwd.x0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        rs2_exec = 5'd9; rd_mem = 5'd9; reg_write_mem = 1'b0; rd_wb = 5'd9; reg_write_wb = 1'b1;
        run("fwd.b_wb", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rs1_exec = 5'($urandom_range(0, 3)); rs2_exec = 5'($urandom_range(0, 3));
            rd_mem = 5'($urandom_range(0, 3));   rd_wb = 5'($urandom_range(0, 3));
            reg_write_mem = 1'($urandom_range(0, 1));
            reg_write_wb  = 1'($urandom_range(0, 1));
            run("fwd.rand", mk(0, 0, 0, 0, 0,
                fwd_model(rs1_exec, rd_mem, reg_write_mem, rd_wb, reg_write_wb),
                fwd_model(rs2_exec, rd_mem, reg_write_mem, rd_wb, reg_write_wb), 0));
        end

        // 3: load-use, branch priority, x0 never hazards
        do_reset();
        idle();
        is_load_exec = 1'b1; rd_exec = 5'd7; rs2_decode = 5'd7;
        run("lu", mk(1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
        @(negedge clk);
        pc_src_exec = 1'b1;
        run("lu.br", mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 0));
        @(negedge clk);
        pc_src_exec = 1'b0; rd_exec = 5'd0; rs1_decode = 5'd0; rs2_decode = 5'd0;
        run("lu.x0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("lu.cnt", 32'(stall_cycles), 32'd1);

        // 4: multi-cycle op finishing after 5 stalled cycles; then a 0-wait op
        do_reset();
        idle();
        mc_start_exec = 1'b1;
        run("mc.start", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            idle();
            run("mc.wait", mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        end
        @(negedge clk);
        mc_done = 1'b1;
        run("mc.done", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        idle();
        run("mc.after", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("mc.cnt", 32'(stall_cycles), 32'd5);
        @(negedge clk);
        mc_start_exec = 1'b1; mc_done = 1'b1;
        run("mc.zero", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        idle();
        run("mc.zero_after", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("mc.zero_cnt", 32'(stall_cycles), 32'd5);

        // 5: timeout with a branch/load-use mid-wait that must be ignored
        do_reset();
        idle();
        mc_start_exec = 1'b1;
        run("to.start", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            idle();
            if (i == 4) begin
                pc_src_exec = 1'b1; is_load_exec = 1'b1; rd_exec = 5'd3; rs1_decode = 5'd3;
            end
            run("to.wait", mk(1, 1, 1, 0, (i == 8), 2'b00, 2'b00, 0));
        end
        @(negedge clk);
        idle();
        run("to.err", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        check_eq("to.cnt", 32'(stall_cycles), 32'd8);
        @(negedge clk);
        run("to.sticky", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1));

        // mc_done on the timeout cycle wins
        do_reset();
        idle();
        mc_start_exec = 1'b1;
        run("tod.start", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            idle();
            run("tod.wait", mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        end
        @(negedge clk);
        mc_done = 1'b1;
        run("tod.done", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        idle();
        run("tod.noerr", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("tod.cnt", 32'(stall_cycles), 32'd7);

        // 6: saturation of the stall counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            idle();
            is_load_exec = 1'b1; rd_exec = 5'd12; rs1_decode = 5'd12;
            run("sat.lu", mk(1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
            check_eq("sat.cnt", 32'(stall_cycles), (i < 15) ? 32'(i) : 32'd15);
        end
        @(negedge clk);
        idle();
        run("sat.idle", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("sat.hold", 32'(stall_cycles), 32'd15);

        // reset in the middle of a wait returns straight to RUN
        do_reset();
        idle();
        mc_start_exec = 1'b1;
        run("rw.start", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle();
            run("rw.wait", mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        run("rw.rst", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        check_eq("rw.cnt", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run("rw.run0", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        @(negedge clk);
        run("rw.run1", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));

        check_eq("sb.drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
